// File: rtl/mem_bridge.sv
// MAR/MDR bridge: latches a word address and data word from the CPU bus and runs one memory access per request.
// Optional macro MEM_WAIT_EN stretches every access by WAIT extra cycles (WAIT in 0..15).
module mem_bridge #(
  parameter int ADDR_W = 9,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [31:0]       MDRdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RD_ACC, WR_ACC, HOLD} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [31:0]       mdr_q;
  logic              done_q;
  logic              err_q;
  logic              acc_last;
  logic              regs_open;

`ifdef MEM_WAIT_EN
  localparam logic [3:0] EFF_WAIT = 4'(WAIT);
  logic [3:0] cnt_q;
  assign acc_last = (cnt_q == 4'd0);
`else
  assign acc_last = 1'b1;
`endif

  // Only the low ADDR_W bits of MAR are kept, so the address wraps naturally.
  assign regs_open = (state_q == IDLE) || (state_q == HOLD);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      done_q <= 1'b0;
      if (regs_open && MARin) mar_q <= BusMuxOut[ADDR_W-1:0];
      if (regs_open && MDRin) mdr_q <= BusMuxOut;
      case (state_q)
        IDLE: begin
          if (Read && Write) begin
            err_q <= 1'b1;
          end else if (Read || Write) begin
            state_q <= Read ? RD_ACC : WR_ACC;
            err_q   <= 1'b0;
`ifdef MEM_WAIT_EN
            cnt_q   <= EFF_WAIT;
`endif
          end
        end
        RD_ACC, WR_ACC: begin
          if (acc_last) begin
            if (state_q == RD_ACC) mdr_q <= mem_rdata;
            done_q  <= 1'b1;
            state_q <= HOLD;
          end
`ifdef MEM_WAIT_EN
          else begin
            cnt_q <= cnt_q - 4'd1;
          end
`endif
        end
        HOLD: begin
          if (!Read && !Write) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MDRdata   = mdr_q;
  assign mem_wdata = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_rd    = (state_q == RD_ACC);
  assign mem_wr    = (state_q == WR_ACC);
  assign busy      = mem_rd || mem_wr;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: reset checks, a vector table, hand-written corner sequences and random traffic vs a word-level model.
module tb_mem_bridge;

`ifdef MEM_WAIT_EN
  localparam int EFF = 3;
`else
  localparam int EFF = 0;
`endif
  localparam int OP_WR = 0, OP_RD = 1, OP_BOTH = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic [31:0] MDRdata, mem_wdata, mem_rdata;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr, busy, done, err;

  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  logic        mem_init;
  logic        ref_err;
  int          n_chk = 0;
  int          n_fail = 0;

  mem_bridge #(.ADDR_W(9), .WAIT(3)) dut (
    .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .MDRdata(MDRdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Word memory seen by the bridge; writes land on any edge with mem_wr high.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_regs(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk); MARin = 1'b1; BusMuxOut = addr;
    @(negedge clk); MARin = 1'b0; MDRin = 1'b1; BusMuxOut = data;
    @(negedge clk); MDRin = 1'b0;
  endtask

  // Counts edges from the current negedge until done is seen (lat = -1 on timeout).
  task automatic wait_done(output int lat, output int rdc, output int wrc);
    lat = -1; rdc = 0; wrc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_rd) rdc++;
      if (mem_wr) wrc++;
      if (mem_rd && mem_wr) chk("strobes_exclusive", 32'd1, 32'd0);
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic do_op(input string tag, input int op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [8:0] e_addr,
                       input logic [31:0] e_mdr, input logic e_err);
    int lat, rdc, wrc;
    load_regs(addr, data);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e_addr));
    if (op == OP_BOTH) begin
      Read = 1'b1; Write = 1'b1;
      @(negedge clk);
      chk({tag, ".err_set"}, 32'(err), 32'd1);
      chk({tag, ".no_strobe"}, {30'd0, mem_rd, mem_wr}, 32'd0);
      chk({tag, ".busy_both"}, 32'(busy), 32'd0);
      Read = 1'b0; Write = 1'b0;
    end else begin
      Read = (op == OP_RD); Write = (op == OP_WR);
      wait_done(lat, rdc, wrc);
      Read = 1'b0; Write = 1'b0;
      chk({tag, ".latency"}, 32'(lat), 32'(EFF + 2));
      chk({tag, ".rd_cycles"}, 32'(rdc), (op == OP_RD) ? 32'(EFF + 1) : 32'd0);
      chk({tag, ".wr_cycles"}, 32'(wrc), (op == OP_WR) ? 32'(EFF + 1) : 32'd0);
      chk({tag, ".busy_hold"}, 32'(busy), 32'd0);
    end
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, ".mdr"}, MDRdata, e_mdr);
    chk({tag, ".err"}, 32'(err), 32'(e_err));
  endtask

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [8:0]  e_addr;
    logic [31:0] e_mdr;
    logic        e_err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int lat, rdc, wrc, dn, bc;
    logic [31:0] e_mdr;
    tbl[0] = '{OP_WR,   32'h0000_0005, 32'hDEAD_BEEF, 9'h005, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{OP_RD,   32'h0000_0005, 32'h1234_5678, 9'h005, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{OP_WR,   32'h0000_0205, 32'hCAFE_F00D, 9'h005, 32'hCAFE_F00D, 1'b0};
    tbl[3] = '{OP_RD,   32'h0000_0005, 32'h0000_0000, 9'h005, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{OP_RD,   32'hFFFF_FFFE, 32'h0000_0000, 9'h1FE, 32'hA500_01FE, 1'b0};
    tbl[5] = '{OP_BOTH, 32'h0000_0010, 32'h1111_1111, 9'h010, 32'h1111_1111, 1'b1};
    tbl[6] = '{OP_RD,   32'h0000_0010, 32'h0000_0000, 9'h010, 32'hA500_0010, 1'b0};
    tbl[7] = '{OP_WR,   32'h0000_01FF, 32'h0BAD_F00D, 9'h1FF, 32'h0BAD_F00D, 1'b0};
    tbl[8] = '{OP_RD,   32'h0000_01FF, 32'h0000_0000, 9'h1FF, 32'h0BAD_F00D, 1'b0};

    for (int i = 0; i < 512; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    ref_err = 1'b0;
    mem_init = 1'b1;
    clr = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    #1;
    chk("rst.mdr", MDRdata, 32'd0);
    chk("rst.addr", 32'(mem_addr), 32'd0);
    chk("rst.flags", {27'd0, mem_rd, mem_wr, busy, done, err}, 32'd0);
    @(negedge clk); @(negedge clk);
    mem_init = 1'b0; clr = 1'b0;

    for (int i = 0; i < 9; i++)
      do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data,
            tbl[i].e_addr, tbl[i].e_mdr, tbl[i].e_err);
    ref_mem[5] = 32'hCAFE_F00D; ref_mem[9'h1FF] = 32'h0BAD_F00D;

    // Request held high across many cycles: one access only.
    load_regs(32'h20, 32'h0);
    Read = 1'b1; dn = 0; bc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bc++;
    end
    Read = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("held.dones", 32'(dn), 32'd1);
    chk("held.busy_cycles", 32'(bc), 32'(EFF + 1));
    chk("held.mdr", MDRdata, ref_mem[9'h020]);

    // MAR load attempted mid-access must be ignored.
    load_regs(32'h40, 32'h0);
    Read = 1'b1; dn = 0;
    @(negedge clk);
    MARin = 1'b1; BusMuxOut = 32'h77;
    @(negedge clk);
    if (done) dn++;
    MARin = 1'b0; Read = 1'b0;
    chk("marin_busy.addr", 32'(mem_addr), 32'h40);
    for (int k = 0; k < EFF + 3; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("marin_busy.dones", 32'(dn), 32'd1);
    chk("marin_busy.mdr", MDRdata, ref_mem[9'h040]);

    // Reset in the middle of a read aborts it asynchronously.
    load_regs(32'h30, 32'h0);
    Read = 1'b1;
    @(negedge clk);
    if (EFF >= 1) @(negedge clk);
    chk("abort.in_access", 32'(mem_rd), 32'd1);
    clr = 1'b1;
    #1;
    chk("abort.flags", {27'd0, mem_rd, mem_wr, busy, done, err}, 32'd0);
    chk("abort.addr", 32'(mem_addr), 32'd0);
    dn = 0;
    for (int k = 0; k < EFF + 3; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort.no_done", 32'(dn), 32'd0);
    chk("abort.mdr", MDRdata, 32'd0);
    clr = 1'b0;
    wait_done(lat, rdc, wrc);
    Read = 1'b0;
    chk("post_rst.latency", 32'(lat), 32'(EFF + 2));
    @(negedge clk); @(negedge clk);
    chk("post_rst.mdr", MDRdata, ref_mem[0]);

    // Random traffic checked against a word-level memory model.
    for (int n = 0; n < 30; n++) begin
      int op;
      logic [31:0] a, d;
      op = ($urandom_range(0, 9) == 0) ? OP_BOTH : (($urandom_range(0, 1) == 0) ? OP_RD : OP_WR);
      a = $urandom; d = $urandom;
      if (op == OP_BOTH) begin
        e_mdr = d; ref_err = 1'b1;
      end else if (op == OP_RD) begin
        e_mdr = ref_mem[a[8:0]]; ref_err = 1'b0;
      end else begin
        e_mdr = d; ref_mem[a[8:0]] = d; ref_err = 1'b0;
      end
      do_op($sformatf("rnd%0d", n), op, a, d, a[8:0], e_mdr, ref_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
